// File: rtl/decode_pkg.sv
// Shared 6502 types: data/address words, mnemonics and addressing modes.
// ILL marks any byte that is not a documented NMOS opcode.
package common_types;

    typedef logic [7:0]  data_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [5:0] {
        ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS, CLC,
        CLD, CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX, INY, JMP,
        JSR, LDA, LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL, ROR, RTI,
        RTS, SBC, SEC, SED, SEI, STA, STX, STY, TAX, TAY, TSX, TXA, TXS, TYA,
        ILL
    } opc_t;

    typedef enum logic [3:0] {
        IMP, ACC, IMM, ZP, ZPX, ZPY, ABS, ABSX, ABSY, IND, INDX, INDY, REL
    } addmod_t;

    typedef struct packed {
        opc_t    opc;
        addmod_t mode;
    } dec_t;

endpackage

// File: rtl/decode_if.sv
// Decoder bus: opcode byte and sample strobe in, decode results and monitor state out.
interface decode_if;
    import common_types::*;

    data_t      instr;
    logic       sample;
    opc_t       opcode;
    addmod_t    mode;
    logic       illegal;
    logic       illegal_seen;
    logic [7:0] illegal_op;

    modport master (
        output instr, sample,
        input  opcode, mode, illegal, illegal_seen, illegal_op
    );

    modport slave (
        input  instr, sample,
        output opcode, mode, illegal, illegal_seen, illegal_op
    );
endinterface

// File: rtl/decode.sv
// Combinational NMOS 6502 opcode decoder with a sticky illegal-opcode monitor.
// Define DECODE_ILLEGAL_CAPTURE_EN to also latch the first illegal byte seen.
module decode
    import common_types::*;
(
    input  logic     clk,
    input  logic     reset,
    decode_if.slave  bus
);

    dec_t dec;
    logic illegal;
    logic seen_q, seen_d;

    always_comb begin
        dec = '{ILL, IMP};
        case (bus.instr)
            8'h69: dec = '{ADC, IMM};   8'h65: dec = '{ADC, ZP};
            8'h75: dec = '{ADC, ZPX};   8'h6D: dec = '{ADC, ABS};
            8'h7D: dec = '{ADC, ABSX};  8'h79: dec = '{ADC, ABSY};
            8'h61: dec = '{ADC, INDX};  8'h71: dec = '{ADC, INDY};
            8'h29: dec = '{AND, IMM};   8'h25: dec = '{AND, ZP};
            8'h35: dec = '{AND, ZPX};   8'h2D: dec = '{AND, ABS};
            8'h3D: dec = '{AND, ABSX};  8'h39: dec = '{AND, ABSY};
            8'h21: dec = '{AND, INDX};  8'h31: dec = '{AND, INDY};
            8'h0A: dec = '{ASL, ACC};   8'h06: dec = '{ASL, ZP};
            8'h16: dec = '{ASL, ZPX};   8'h0E: dec = '{ASL, ABS};
            8'h1E: dec = '{ASL, ABSX};
            8'h90: dec = '{BCC, REL};   8'hB0: dec = '{BCS, REL};
            8'hF0: dec = '{BEQ, REL};   8'h30: dec = '{BMI, REL};
            8'hD0: dec = '{BNE, REL};   8'h10: dec = '{BPL, REL};
            8'h50: dec = '{BVC, REL};   8'h70: dec = '{BVS, REL};
            8'h24: dec = '{BIT, ZP};    8'h2C: dec = '{BIT, ABS};
            8'h00: dec = '{BRK, IMP};
            8'h18: dec = '{CLC, IMP};   8'hD8: dec = '{CLD, IMP};
            8'h58: dec = '{CLI, IMP};   8'hB8: dec = '{CLV, IMP};
            8'hC9: dec = '{CMP, IMM};   8'hC5: dec = '{CMP, ZP};
            8'hD5: dec = '{CMP, ZPX};   8'hCD: dec = '{CMP, ABS};
            8'hDD: dec = '{CMP, ABSX};  8'hD9: dec = '{CMP, ABSY};
            8'hC1: dec = '{CMP, INDX};  8'hD1: dec = '{CMP, INDY};
            8'hE0: dec = '{CPX, IMM};   8'hE4: dec = '{CPX, ZP};
            8'hEC: dec = '{CPX, ABS};
            8'hC0: dec = '{CPY, IMM};   8'hC4: dec = '{CPY, ZP};
            8'hCC: dec = '{CPY, ABS};
            8'hC6: dec = '{DEC, ZP};    8'hD6: dec = '{DEC, ZPX};
            8'hCE: dec = '{DEC, ABS};   8'hDE: dec = '{DEC, ABSX};
            8'hCA: dec = '{DEX, IMP};   8'h88: dec = '{DEY, IMP};
            8'h49: dec = '{EOR, IMM};   8'h45: dec = '{EOR, ZP};
            8'h55: dec = '{EOR, ZPX};   8'h4D: dec = '{EOR, ABS};
            8'h5D: dec = '{EOR, ABSX};  8'h59: dec = '{EOR, ABSY};
            8'h41: dec = '{EOR, INDX};  8'h51: dec = '{EOR, INDY};
            8'hE6: dec = '{INC, ZP};    8'hF6: dec = '{INC, ZPX};
            8'hEE: dec = '{INC, ABS};   8'hFE: dec = '{INC, ABSX};
            8'hE8: dec = '{INX, IMP};   8'hC8: dec = '{INY, IMP};
            8'h4C: dec = '{JMP, ABS};   8'h6C: dec = '{JMP, IND};
            8'h20: dec = '{JSR, ABS};
            8'hA9: dec = '{LDA, IMM};   8'hA5: dec = '{LDA, ZP};
            8'hB5: dec = '{LDA, ZPX};   8'hAD: dec = '{LDA, ABS};
            8'hBD: dec = '{LDA, ABSX};  8'hB9: dec = '{LDA, ABSY};
            8'hA1: dec = '{LDA, INDX};  8'hB1: dec = '{LDA, INDY};
            // LDX/STX index through Y, not X
            8'hA2: dec = '{LDX, IMM};   8'hA6: dec = '{LDX, ZP};
            8'hB6: dec = '{LDX, ZPY};   8'hAE: dec = '{LDX, ABS};
            8'hBE: dec = '{LDX, ABSY};
            8'hA0: dec = '{LDY, IMM};   8'hA4: dec = '{LDY, ZP};
            8'hB4: dec = '{LDY, ZPX};   8'hAC: dec = '{LDY, ABS};
            8'hBC: dec = '{LDY, ABSX};
            8'h4A: dec = '{LSR, ACC};   8'h46: dec = '{LSR, ZP};
            8'h56: dec = '{LSR, ZPX};   8'h4E: dec = '{LSR, ABS};
            8'h5E: dec = '{LSR, ABSX};
            8'hEA: dec = '{NOP, IMP};
            8'h09: dec = '{ORA, IMM};   8'h05: dec = '{ORA, ZP};
            8'h15: dec = '{ORA, ZPX};   8'h0D: dec = '{ORA, ABS};
            8'h1D: dec = '{ORA, ABSX};  8'h19: dec = '{ORA, ABSY};
            8'h01: dec = '{ORA, INDX};  8'h11: dec = '{ORA, INDY};
            8'h48: dec = '{PHA, IMP};   8'h08: dec = '{PHP, IMP};
            8'h68: dec = '{PLA, IMP};   8'h28: dec = '{PLP, IMP};
            8'h2A: dec = '{ROL, ACC};   8'h26: dec = '{ROL, ZP};
            8'h36: dec = '{ROL, ZPX};   8'h2E: dec = '{ROL, ABS};
            8'h3E: dec = '{ROL, ABSX};
            8'h6A: dec = '{ROR, ACC};   8'h66: dec = '{ROR, ZP};
            8'h76: dec = '{ROR, ZPX};   8'h6E: dec = '{ROR, ABS};
            8'h7E: dec = '{ROR, ABSX};
            8'h40: dec = '{RTI, IMP};   8'h60: dec = '{RTS, IMP};
            8'hE9: dec = '{SBC, IMM};   8'hE5: dec = '{SBC, ZP};
            8'hF5: dec = '{SBC, ZPX};   8'hED: dec = '{SBC, ABS};
            8'hFD: dec = '{SBC, ABSX};  8'hF9: dec = '{SBC, ABSY};
            8'hE1: dec = '{SBC, INDX};  8'hF1: dec = '{SBC, INDY};
            8'h38: dec = '{SEC, IMP};   8'hF8: dec = '{SED, IMP};
            8'h78: dec = '{SEI, IMP};
            8'h85: dec = '{STA, ZP};    8'h95: dec = '{STA, ZPX};
            8'h8D: dec = '{STA, ABS};   8'h9D: dec = '{STA, ABSX};
            8'h99: dec = '{STA, ABSY};  8'h81: dec = '{STA, INDX};
            8'h91: dec = '{STA, INDY};
            8'h86: dec = '{STX, ZP};    8'h96: dec = '{STX, ZPY};
            8'h8E: dec = '{STX, ABS};
            8'h84: dec = '{STY, ZP};    8'h94: dec = '{STY, ZPX};
            8'h8C: dec = '{STY, ABS};
            8'hAA: dec = '{TAX, IMP};   8'hA8: dec = '{TAY, IMP};
            8'hBA: dec = '{TSX, IMP};   8'h8A: dec = '{TXA, IMP};
            8'h9A: dec = '{TXS, IMP};   8'h98: dec = '{TYA, IMP};
            default: dec = '{ILL, IMP};
        endcase
    end

    assign illegal     = (dec.opc == ILL);
    assign bus.opcode  = dec.opc;
    assign bus.mode    = dec.mode;
    assign bus.illegal = illegal;

    // Only the first qualifying illegal sample after reset is recorded.
    always_comb begin
        seen_d = seen_q;
        if (bus.sample && illegal && !seen_q) begin
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign bus.illegal_seen = seen_q;

`ifdef DECODE_ILLEGAL_CAPTURE_EN
    logic [7:0] iop_q, iop_d;

    always_comb begin
        iop_d = iop_q;
        if (bus.sample && illegal && !seen_q) begin
            iop_d = bus.instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iop_q <= 8'h00;
        end else begin
            iop_q <= iop_d;
        end
    end

    assign bus.illegal_op = iop_q;
`else
    assign bus.illegal_op = 8'h00;
`endif

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: driver queues expectations, a negedge monitor checks them.
module tb_decode;
    import common_types::*;

    typedef enum int { K_DEC, K_MON, K_SWEEP, K_COUNT } kind_e;

    typedef struct {
        kind_e      kind;
        string      name;
        logic [7:0] ins;
        opc_t       opc;
        addmod_t    md;
        logic       ill;
        logic       seen;
        logic [7:0] iop;
    } item_t;

`ifdef DECODE_ILLEGAL_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk;
    logic reset;
    decode_if bus();

    decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    item_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    legal_cnt = 0;

    function automatic logic [7:0] exp_iop(input logic [7:0] b);
        return CAP ? b : 8'h00;
    endfunction

    task automatic cmp(input string nm, input logic [7:0] ins, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s instr=%02h actual=%0h required=%0h", nm, ins, act, req);
        end
    endtask

    // Monitor: drain everything queued for this cycle at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            item_t it;
            it = exp_q.pop_front();
            case (it.kind)
                K_DEC: begin
                    cmp({it.name, "_opcode"},  it.ins, int'(bus.opcode),  int'(it.opc));
                    cmp({it.name, "_mode"},    it.ins, int'(bus.mode),    int'(it.md));
                    cmp({it.name, "_illegal"}, it.ins, int'(bus.illegal), int'(it.ill));
                end
                K_MON: begin
                    cmp({it.name, "_seen"}, it.ins, int'(bus.illegal_seen), int'(it.seen));
                    cmp({it.name, "_iop"},  it.ins, int'(bus.illegal_op),   int'(it.iop));
                end
                K_SWEEP: begin
                    if (!bus.illegal) legal_cnt++;
                    if (bus.illegal) begin
                        cmp("sweep_ill_opcode", it.ins, int'(bus.opcode), int'(ILL));
                        cmp("sweep_ill_mode",   it.ins, int'(bus.mode),   int'(IMP));
                    end else begin
                        cmp("sweep_legal_not_ill", it.ins, int'(bus.opcode == ILL), 0);
                    end
                    if (it.ins[1:0] == 2'b11)
                        cmp("sweep_cc11_illegal", it.ins, int'(bus.illegal), 1);
                end
                K_COUNT: cmp("legal_count", it.ins, legal_cnt, 151);
                default: ;
            endcase
        end
    end

    task automatic step(input logic [7:0] ins, input logic smp, input logic rst);
        @(posedge clk);
        #1;
        bus.instr  = ins;
        bus.sample = smp;
        reset      = rst;
    endtask

    task automatic push(input kind_e k, input string nm, input opc_t o, input addmod_t m,
                        input logic il, input logic sn, input logic [7:0] ip);
        item_t it;
        it.kind = k; it.name = nm; it.ins = bus.instr; it.opc = o; it.md = m;
        it.ill = il; it.seen = sn; it.iop = ip;
        exp_q.push_back(it);
    endtask

    task automatic dec_vec(input logic [7:0] b, input opc_t o, input addmod_t m, input logic il);
        step(b, 1'b0, 1'b0);
        push(K_DEC, "dec", o, m, il, 1'b0, 8'h00);
    endtask

    task automatic mon_chk(input string nm, input logic sn, input logic [7:0] ip);
        push(K_MON, nm, ILL, IMP, 1'b0, sn, ip);
    endtask

    initial begin
        reset      = 1'b1;
        bus.instr  = 8'h00;
        bus.sample = 1'b0;

        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        mon_chk("reset_state", 1'b0, 8'h00);
        step(8'h00, 1'b0, 1'b0);

        dec_vec(8'hA2, LDX, IMM,  1'b0);
        dec_vec(8'hA6, LDX, ZP,   1'b0);
        dec_vec(8'hB6, LDX, ZPY,  1'b0);
        dec_vec(8'hAE, LDX, ABS,  1'b0);
        dec_vec(8'hBE, LDX, ABSY, 1'b0);
        dec_vec(8'hE8, INX, IMP,  1'b0);
        dec_vec(8'h4C, JMP, ABS,  1'b0);
        dec_vec(8'h6C, JMP, IND,  1'b0);
        dec_vec(8'hF0, BEQ, REL,  1'b0);
        dec_vec(8'h0A, ASL, ACC,  1'b0);
        dec_vec(8'hA1, LDA, INDX, 1'b0);
        dec_vec(8'hB1, LDA, INDY, 1'b0);
        dec_vec(8'h20, JSR, ABS,  1'b0);
        dec_vec(8'h00, BRK, IMP,  1'b0);
        dec_vec(8'h96, STX, ZPY,  1'b0);
        dec_vec(8'h71, ADC, INDY, 1'b0);
        dec_vec(8'h6A, ROR, ACC,  1'b0);
        dec_vec(8'h10, BPL, REL,  1'b0);
        dec_vec(8'h02, ILL, IMP,  1'b1);
        dec_vec(8'hFF, ILL, IMP,  1'b1);
        dec_vec(8'h80, ILL, IMP,  1'b1);
        dec_vec(8'h1A, ILL, IMP,  1'b1);

        for (int i = 0; i < 256; i++) begin
            step(8'(i), 1'b0, 1'b0);
            push(K_SWEEP, "sweep", ILL, IMP, 1'b0, 1'b0, 8'h00);
        end
        step(8'h00, 1'b0, 1'b0);
        push(K_COUNT, "count", ILL, IMP, 1'b0, 1'b0, 8'h00);
        mon_chk("sweep_no_sample", 1'b0, 8'h00);

        // First illegal capture, then later illegal bytes must not overwrite
        step(8'h02, 1'b1, 1'b0);
        step(8'h03, 1'b1, 1'b0);
        mon_chk("capture_first", 1'b1, exp_iop(8'h02));
        step(8'hEA, 1'b1, 1'b0);
        mon_chk("capture_hold", 1'b1, exp_iop(8'h02));
        step(8'h00, 1'b0, 1'b0);
        mon_chk("capture_sticky", 1'b1, exp_iop(8'h02));

        step(8'h00, 1'b0, 1'b1);
        step(8'h02, 1'b0, 1'b0);
        mon_chk("reset_clear", 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(8'h02, 1'b0, 1'b0);
            mon_chk("no_sample", 1'b0, 8'h00);
        end

        step(8'hFF, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        mon_chk("capture_ff", 1'b1, exp_iop(8'hFF));
        step(8'hFF, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        mon_chk("reset_wins_set", 1'b0, 8'h00);
        step(8'hFF, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        mon_chk("reset_wins_clear", 1'b0, 8'h00);

        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            n_chk++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain actual=%0d left required=0", exp_q.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
